// File: rtl/tsn_cbs_shaper_if.sv
// Port-side bundle of the credit-based shaper: scheduler, MAC frame markers,
// configuration and debug signals.
interface tsn_cbs_shaper_if #(
    parameter int unsigned QUEUE_NUM = 8,
    parameter int unsigned CREDIT_W  = 20,
    parameter int unsigned SLOPE_W   = 12,
    parameter int unsigned QID_W     = 3
);
    logic [QUEUE_NUM-1:0] i_cbs_en;
    logic [QUEUE_NUM-1:0] i_q_empty;
    logic                 i_sched_req;
    logic [QUEUE_NUM-1:0] o_elig;
    logic                 o_elig_vld;
    logic                 i_tx_start;
    logic [QID_W-1:0]     i_tx_qid;
    logic                 i_tx_end;
    logic                 i_cfg_wr;
    logic [QID_W-1:0]     i_cfg_qid;
    logic [SLOPE_W-1:0]   i_cfg_idle;
    logic [SLOPE_W-1:0]   i_cfg_send;
    logic [CREDIT_W-1:0]  i_cfg_hi;
    logic [CREDIT_W-1:0]  i_cfg_lo;
    logic                 i_cfg_commit;
    logic                 o_cfg_busy;
    logic                 o_err;
    logic [QID_W-1:0]     i_dbg_qid;
    logic [CREDIT_W-1:0]  o_dbg_credit;

    modport slave (
        input  i_cbs_en, i_q_empty, i_sched_req, i_tx_start, i_tx_qid, i_tx_end,
               i_cfg_wr, i_cfg_qid, i_cfg_idle, i_cfg_send, i_cfg_hi, i_cfg_lo,
               i_cfg_commit, i_dbg_qid,
        output o_elig, o_elig_vld, o_cfg_busy, o_err, o_dbg_credit
    );

    modport master (
        output i_cbs_en, i_q_empty, i_sched_req, i_tx_start, i_tx_qid, i_tx_end,
               i_cfg_wr, i_cfg_qid, i_cfg_idle, i_cfg_send, i_cfg_hi, i_cfg_lo,
               i_cfg_commit, i_dbg_qid,
        input  o_elig, o_elig_vld, o_cfg_busy, o_err, o_dbg_credit
    );
endinterface

// File: rtl/tsn_cbs_shaper.sv
// 802.1Qav credit-based shaper for one egress port: per-queue signed credit,
// registered eligibility mask, shadow config applied only between frames.
module tsn_cbs_shaper #(
    parameter int unsigned QUEUE_NUM = 8,
    parameter int unsigned CREDIT_W  = 20,
    parameter int unsigned SLOPE_W   = 12,
    parameter int unsigned QID_W     = 3
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    tsn_cbs_shaper_if.slave bus
);
    localparam int unsigned SUM_W = CREDIT_W + 1;

    typedef enum logic {ST_IDLE, ST_TX} state_t;

    state_t                     r_state;
    logic [QID_W-1:0]           r_cur_q;
    logic                       r_err;
    logic                       r_pending;
    logic [QUEUE_NUM-1:0]       r_elig;
    logic                       r_elig_vld;
    logic [CREDIT_W-1:0]        r_dbg_credit;

    logic [SLOPE_W-1:0]         r_sh_idle [QUEUE_NUM];
    logic [SLOPE_W-1:0]         r_sh_send [QUEUE_NUM];
    logic signed [CREDIT_W-1:0] r_sh_hi   [QUEUE_NUM];
    logic signed [CREDIT_W-1:0] r_sh_lo   [QUEUE_NUM];
    logic [SLOPE_W-1:0]         r_act_idle[QUEUE_NUM];
    logic [SLOPE_W-1:0]         r_act_send[QUEUE_NUM];
    logic signed [CREDIT_W-1:0] r_act_hi  [QUEUE_NUM];
    logic signed [CREDIT_W-1:0] r_act_lo  [QUEUE_NUM];
    logic signed [CREDIT_W-1:0] r_credit  [QUEUE_NUM];

    logic                       w_apply;
    logic signed [CREDIT_W-1:0] w_credit_nxt [QUEUE_NUM];
    logic [QUEUE_NUM-1:0]       w_elig;

    // Saturating credit step for one enabled queue, evaluated one bit wider than the credit.
    function automatic logic signed [CREDIT_W-1:0] f_credit_nxt(
        input logic signed [CREDIT_W-1:0] cr,
        input logic [SLOPE_W-1:0]         idle,
        input logic [SLOPE_W-1:0]         send,
        input logic signed [CREDIT_W-1:0] hi,
        input logic signed [CREDIT_W-1:0] lo,
        input logic                       in_tx,
        input logic                       empty
    );
        logic signed [SUM_W-1:0]    v_cr;
        logic signed [SUM_W-1:0]    v_sum;
        logic signed [CREDIT_W-1:0] v_res;
        v_cr  = SUM_W'(cr);
        v_sum = '0;
        v_res = '0;
        if (in_tx) begin
            v_sum = v_cr - $signed(SUM_W'(send));
            if (v_sum < SUM_W'(lo)) v_sum = SUM_W'(lo);
            v_res = v_sum[CREDIT_W-1:0];
        end else if (!empty || cr < 0) begin
            v_sum = v_cr + $signed(SUM_W'(idle));
            if (v_sum > SUM_W'(hi)) v_sum = SUM_W'(hi);
            if (empty && v_sum > 0) v_sum = '0;
            v_res = v_sum[CREDIT_W-1:0];
        end
        return v_res;
    endfunction

    // Config only switches banks when no frame is in flight or starting.
    assign w_apply = r_pending && (r_state == ST_IDLE) && !bus.i_tx_start;

    always_comb begin
        for (int q = 0; q < QUEUE_NUM; q++) begin
            w_credit_nxt[q] = '0;
            w_elig[q]       = bus.i_q_empty[q] ? 1'b0
                              : (!r_credit[q][CREDIT_W-1] || !bus.i_cbs_en[q]);
            if (bus.i_cbs_en[q]) begin
                w_credit_nxt[q] = f_credit_nxt(r_credit[q], r_act_idle[q], r_act_send[q],
                                               r_act_hi[q], r_act_lo[q],
                                               (r_state == ST_TX) && (r_cur_q == QID_W'(q)),
                                               bus.i_q_empty[q]);
            end
        end
    end

    // Port frame tracking; back-to-back end+start keeps the port in TX on the new queue.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cur_q <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_tx_start) begin
                        r_state <= ST_TX;
                        r_cur_q <= bus.i_tx_qid;
                    end
                    if (bus.i_tx_end) r_err <= 1'b1;
                end
                ST_TX: begin
                    if (bus.i_tx_end) begin
                        if (bus.i_tx_start) r_cur_q <= bus.i_tx_qid;
                        else                r_state <= ST_IDLE;
                    end else if (bus.i_tx_start) begin
                        r_err <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= 1'b0;
            for (int q = 0; q < QUEUE_NUM; q++) begin
                r_sh_idle[q]  <= '0;
                r_sh_send[q]  <= '0;
                r_sh_hi[q]    <= '0;
                r_sh_lo[q]    <= '0;
                r_act_idle[q] <= '0;
                r_act_send[q] <= '0;
                r_act_hi[q]   <= '0;
                r_act_lo[q]   <= '0;
            end
        end else begin
            r_pending <= w_apply ? 1'b0 : (r_pending | bus.i_cfg_commit);
            if (w_apply) begin
                for (int q = 0; q < QUEUE_NUM; q++) begin
                    r_act_idle[q] <= r_sh_idle[q];
                    r_act_send[q] <= r_sh_send[q];
                    r_act_hi[q]   <= r_sh_hi[q];
                    r_act_lo[q]   <= r_sh_lo[q];
                end
            end
            if (bus.i_cfg_wr) begin
                r_sh_idle[bus.i_cfg_qid] <= bus.i_cfg_idle;
                r_sh_send[bus.i_cfg_qid] <= bus.i_cfg_send;
                r_sh_hi[bus.i_cfg_qid]   <= bus.i_cfg_hi;
                r_sh_lo[bus.i_cfg_qid]   <= bus.i_cfg_lo;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_elig       <= '0;
            r_elig_vld   <= 1'b0;
            r_dbg_credit <= '0;
            for (int q = 0; q < QUEUE_NUM; q++) r_credit[q] <= '0;
        end else begin
            r_elig       <= w_elig;
            r_elig_vld   <= bus.i_sched_req;
            r_dbg_credit <= r_credit[bus.i_dbg_qid];
            for (int q = 0; q < QUEUE_NUM; q++)
                r_credit[q] <= w_apply ? '0 : w_credit_nxt[q];
        end
    end

    assign bus.o_elig       = r_elig;
    assign bus.o_elig_vld   = r_elig_vld;
    assign bus.o_cfg_busy   = r_pending;
    assign bus.o_err        = r_err;
    assign bus.o_dbg_credit = r_dbg_credit;
endmodule

// File: tb/tb_tsn_cbs_shaper.sv
// Randomized and directed bench for tsn_cbs_shaper against an integer-arithmetic
// reference of the shaper rules.
module tb_tsn_cbs_shaper;
    localparam int unsigned QN = 8;
    localparam int unsigned CW = 20;
    localparam int unsigned SW = 12;
    localparam int unsigned QW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #2 clk = ~clk;

    tsn_cbs_shaper_if #(.QUEUE_NUM(QN), .CREDIT_W(CW), .SLOPE_W(SW), .QID_W(QW)) bus();

    tsn_cbs_shaper #(.QUEUE_NUM(QN), .CREDIT_W(CW), .SLOPE_W(SW), .QID_W(QW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    int m_credit [QN];
    int m_sh_idle[QN], m_sh_send[QN], m_sh_hi[QN], m_sh_lo[QN];
    int m_ac_idle[QN], m_ac_send[QN], m_ac_hi[QN], m_ac_lo[QN];
    bit m_tx;
    int m_cur;
    bit m_pend;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int q = 0; q < QN; q++) begin
            m_credit[q] = 0;
            m_sh_idle[q] = 0; m_sh_send[q] = 0; m_sh_hi[q] = 0; m_sh_lo[q] = 0;
            m_ac_idle[q] = 0; m_ac_send[q] = 0; m_ac_hi[q] = 0; m_ac_lo[q] = 0;
        end
        m_tx = 0; m_cur = 0; m_pend = 0;
    endtask

    task automatic idle_inputs();
        bus.i_sched_req = 0; bus.i_tx_start = 0; bus.i_tx_end = 0;
        bus.i_cfg_wr = 0; bus.i_cfg_commit = 0;
    endtask

    // One clock: predict from the inputs now applied, advance the model, compare after the edge.
    task automatic step();
        int nc[QN];
        int e_elig, e_vld, e_err, e_dbg, s;
        bit apply, start, fin, wr;
        int wq, widle, wsend, whi, wlo, sq;
        e_elig = 0;
        for (int q = 0; q < QN; q++)
            if (!bus.i_q_empty[q] && (m_credit[q] >= 0 || !bus.i_cbs_en[q])) e_elig |= (1 << q);
        e_vld = int'(bus.i_sched_req);
        e_dbg = m_credit[bus.i_dbg_qid];
        start = bus.i_tx_start; fin = bus.i_tx_end; sq = int'(bus.i_tx_qid);
        e_err = m_tx ? int'(start && !fin) : int'(fin);
        apply = m_pend && !m_tx && !start;
        for (int q = 0; q < QN; q++) begin
            if (apply || !bus.i_cbs_en[q]) begin
                nc[q] = 0;
            end else if (m_tx && m_cur == q) begin
                s = m_credit[q] - m_ac_send[q];
                nc[q] = (s < m_ac_lo[q]) ? m_ac_lo[q] : s;
            end else if (!bus.i_q_empty[q] || m_credit[q] < 0) begin
                s = m_credit[q] + m_ac_idle[q];
                if (s > m_ac_hi[q]) s = m_ac_hi[q];
                if (bus.i_q_empty[q] && s > 0) s = 0;
                nc[q] = s;
            end else begin
                nc[q] = 0;
            end
        end
        wr = bus.i_cfg_wr; wq = int'(bus.i_cfg_qid);
        widle = int'(bus.i_cfg_idle); wsend = int'(bus.i_cfg_send);
        whi = int'($signed(bus.i_cfg_hi)); wlo = int'($signed(bus.i_cfg_lo));
        m_pend = apply ? 1'b0 : (m_pend || bus.i_cfg_commit);

        @(posedge clk);
        #1;
        for (int q = 0; q < QN; q++) begin
            m_credit[q] = nc[q];
            if (apply) begin
                m_ac_idle[q] = m_sh_idle[q]; m_ac_send[q] = m_sh_send[q];
                m_ac_hi[q] = m_sh_hi[q]; m_ac_lo[q] = m_sh_lo[q];
            end
        end
        if (wr) begin
            m_sh_idle[wq] = widle; m_sh_send[wq] = wsend; m_sh_hi[wq] = whi; m_sh_lo[wq] = wlo;
        end
        if (!m_tx) begin
            if (start) begin m_tx = 1; m_cur = sq; end
        end else if (fin) begin
            if (start) m_cur = sq; else m_tx = 0;
        end
        check("elig", int'(bus.o_elig), e_elig);
        check("elig_vld", int'(bus.o_elig_vld), e_vld);
        check("err", int'(bus.o_err), e_err);
        check("cfg_busy", int'(bus.o_cfg_busy), int'(m_pend));
        check("dbg_credit", int'($signed(bus.o_dbg_credit)), e_dbg);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cfg_write(input int q, input int idle, input int send, input int hi, input int lo);
        bus.i_cfg_wr = 1; bus.i_cfg_qid = QW'(q);
        bus.i_cfg_idle = SW'(idle); bus.i_cfg_send = SW'(send);
        bus.i_cfg_hi = CW'(hi); bus.i_cfg_lo = CW'(lo);
        step();
        bus.i_cfg_wr = 0;
    endtask

    task automatic commit_now();
        bus.i_cfg_commit = 1;
        step();
        bus.i_cfg_commit = 0;
        for (int i = 0; i < 8 && m_pend; i++) step();
        check("commit_done", int'(bus.o_cfg_busy), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_elig"}, int'(bus.o_elig), 0);
        check({tag, "_vld"}, int'(bus.o_elig_vld), 0);
        check({tag, "_busy"}, int'(bus.o_cfg_busy), 0);
        check({tag, "_err"}, int'(bus.o_err), 0);
        check({tag, "_dbg"}, int'(bus.o_dbg_credit), 0);
    endtask

    initial begin
        idle_inputs();
        bus.i_cbs_en = '0; bus.i_q_empty = '1; bus.i_tx_qid = '0;
        bus.i_cfg_qid = '0; bus.i_cfg_idle = '0; bus.i_cfg_send = '0;
        bus.i_cfg_hi = '0; bus.i_cfg_lo = '0; bus.i_dbg_qid = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1;

        // T1: q0 frame of 10 TX clocks from credit 0, then recovery at idleSlope.
        cfg_write(0, 4, 12, 100, -200);
        commit_now();
        bus.i_cbs_en = 8'h01;
        bus.i_tx_start = 1; bus.i_tx_qid = 3'd0;
        step();
        bus.i_tx_start = 0; bus.i_q_empty = 8'hFE;
        steps(9);
        bus.i_tx_end = 1;
        step();
        bus.i_tx_end = 0;
        step();
        check("t1_credit", int'($signed(bus.o_dbg_credit)), -120);
        check("t1_inelig", int'(bus.o_elig[0]), 0);
        steps(30);
        check("t1_elig_back", int'(bus.o_elig[0]), 1);

        // T2: long frame saturates at loCredit.
        bus.i_tx_start = 1; bus.i_tx_qid = 3'd0;
        step();
        bus.i_tx_start = 0;
        steps(19);
        bus.i_tx_end = 1;
        step();
        bus.i_tx_end = 0;
        step();
        check("t2_lo_clamp", int'($signed(bus.o_dbg_credit)), -200);
        steps(55);

        // T3: positive credit dropped on empty; negative credit recovers to 0 while empty.
        cfg_write(1, 4, 8, 100, -200);
        commit_now();
        bus.i_cbs_en = 8'h03; bus.i_dbg_qid = 3'd1; bus.i_q_empty = 8'hFC;
        steps(15);
        bus.i_q_empty = 8'hFE;
        step();
        check("t3_at_60", int'($signed(bus.o_dbg_credit)), 60);
        step();
        check("t3_empty_zero", int'($signed(bus.o_dbg_credit)), 0);
        bus.i_tx_start = 1; bus.i_tx_qid = 3'd1;
        step();
        bus.i_tx_start = 0; bus.i_tx_end = 1;
        step();
        bus.i_tx_end = 0;
        steps(4);

        // T4: commit while a frame is in flight waits for the frame end.
        cfg_write(0, 6, 10, 150, -150);
        bus.i_tx_start = 1; bus.i_tx_qid = 3'd0;
        step();
        bus.i_tx_start = 0; bus.i_cfg_commit = 1;
        step();
        bus.i_cfg_commit = 0;
        steps(5);
        check("t4_busy_mid", int'(bus.o_cfg_busy), 1);
        bus.i_tx_end = 1;
        step();
        bus.i_tx_end = 0;
        steps(3);

        // T5: shapers disabled, eligibility follows non-empty flags.
        bus.i_cbs_en = 8'h00; bus.i_q_empty = 8'h5A; bus.i_sched_req = 1;
        step();
        bus.i_sched_req = 0;
        check("t5_elig", int'(bus.o_elig), 32'hA5);
        check("t5_vld", int'(bus.o_elig_vld), 1);
        step();

        // T6: back-to-back frames and an illegal second start.
        bus.i_cbs_en = 8'hFF; bus.i_q_empty = 8'h00;
        bus.i_tx_start = 1; bus.i_tx_qid = 3'd2;
        step();
        bus.i_tx_start = 0;
        steps(2);
        bus.i_tx_start = 1; bus.i_tx_end = 1; bus.i_tx_qid = 3'd5;
        step();
        bus.i_tx_end = 0;
        step();
        check("t6_err_pulse", int'(bus.o_err), 1);
        bus.i_tx_start = 0;
        step();
        bus.i_tx_end = 1;
        step();
        bus.i_tx_end = 0;
        bus.i_tx_end = 1;
        step();
        check("t6_err_idle_end", int'(bus.o_err), 1);
        bus.i_tx_end = 0;

        // Randomized traffic, configuration and scheduler requests.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 31) == 0) bus.i_cbs_en = QN'($urandom);
            bus.i_q_empty   = QN'($urandom) & QN'($urandom);
            bus.i_sched_req = ($urandom_range(0, 3) == 0);
            bus.i_tx_start  = ($urandom_range(0, 9) == 0);
            bus.i_tx_end    = ($urandom_range(0, 7) == 0);
            bus.i_tx_qid    = QW'($urandom);
            bus.i_dbg_qid   = QW'($urandom);
            bus.i_cfg_commit = ($urandom_range(0, 39) == 0);
            bus.i_cfg_wr    = ($urandom_range(0, 9) == 0);
            bus.i_cfg_qid   = QW'($urandom);
            bus.i_cfg_idle  = SW'($urandom_range(0, 40));
            bus.i_cfg_send  = SW'($urandom_range(0, 60));
            bus.i_cfg_hi    = CW'($urandom_range(0, 400));
            bus.i_cfg_lo    = CW'(-int'($urandom_range(0, 400)));
            step();
        end
        idle_inputs();

        // Reset in the middle of a frame with a commit pending.
        bus.i_tx_start = 1; bus.i_tx_qid = 3'd4;
        step();
        bus.i_tx_start = 0; bus.i_cfg_commit = 1;
        step();
        bus.i_cfg_commit = 0;
        rst_n = 0;
        #1;
        check_outputs_zero("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        bus.i_tx_end = 1;
        step();
        bus.i_tx_end = 0;
        steps(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
